// File: rtl/rv_regfile.sv
// rv_regfile: general-purpose register file with two combinational read
// ports and one synchronous write port. Address 0 always reads zero.
//
// After reset the file sweeps every entry to zero, one entry per clock,
// and only then raises ready and accepts writes. Reset itself does not
// touch the storage array; the sweep does.
//
// Parameters:
//   DATA_W  register width in bits
//   DEPTH   number of registers (power of two, 4..256)
//   ADDR_W  address width, $clog2(DEPTH)
//
// Ports:
//   clk       clock, all state changes on the rising edge
//   reset     synchronous active-high reset, restarts the clear sweep
//   wr_en     write enable (ignored while clearing)
//   wr_reg    write address
//   wr_data   write data
//   rd_reg1   read port 1 address
//   rd_reg2   read port 2 address
//   rd_data1  read port 1 data (combinational, zero while clearing)
//   rd_data2  read port 2 data (combinational, zero while clearing)
//   ready     high once the clear sweep has finished
//
// Optional feature (macro RF_BYPASS_EN):
//   When defined, a read of the address being written in the same cycle
//   returns the incoming write data instead of the stored value.
//   When undefined, the old stored value is returned until the edge.

module rv_regfile #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_reg,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_reg1,
    input  logic [ADDR_W-1:0] rd_reg2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic              ready
);

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(DEPTH - 1);

    state_t              state_q;
    logic [ADDR_W-1:0]   clr_cnt_q;
    logic [ADDR_W-1:0]   clr_cnt_d;
    logic                ready_q;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic                wr_fire;

    // Increment wraps DEPTH-1 -> 0 naturally since DEPTH is a power of two.
    assign clr_cnt_d = clr_cnt_q + ADDR_W'(1);

    // A write only lands when the file is up, reset is low and the target
    // is not the hardwired-zero register.
    assign wr_fire = (state_q == READY) && !reset && wr_en && (wr_reg != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= CLEAR;
            clr_cnt_q <= '0;
            ready_q   <= 1'b0;
        end else begin
            case (state_q)
                CLEAR: begin
                    clr_cnt_q <= clr_cnt_d;
                    if (clr_cnt_q == CLR_LAST) begin
                        state_q <= READY;
                        ready_q <= 1'b1;
                    end
                end
                READY: begin
                    clr_cnt_q <= '0;
                    ready_q   <= 1'b1;
                end
                default: begin
                    state_q   <= CLEAR;
                    clr_cnt_q <= '0;
                    ready_q   <= 1'b0;
                end
            endcase
        end
    end

    // Storage has no reset; the sweep zeroes it one entry per cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state_q == CLEAR) begin
                mem_q[clr_cnt_q] <= '0;
            end else if (wr_fire) begin
                mem_q[wr_reg] <= wr_data;
            end
        end
    end

    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] val;
        val = '0;
        if ((state_q == READY) && (addr != '0)) begin
`ifdef RF_BYPASS_EN
            if (wr_fire && (wr_reg == addr)) begin
                val = wr_data;
            end else begin
                val = mem_q[addr];
            end
`else
            val = mem_q[addr];
`endif
        end
        return val;
    endfunction

    assign rd_data1 = read_port(rd_reg1);
    assign rd_data2 = read_port(rd_reg2);
    assign ready    = ready_q;

endmodule

// File: tb/tb_rv_regfile.sv
// Directed bench for rv_regfile: a 32x32 instance and a 64x64 instance.
// Expected read values are queued when a read is set up and popped when
// the combinational outputs are sampled.

module tb_rv_regfile;

    logic        clk;
    logic        reset;
    logic        wr_en;
    logic [4:0]  wr_reg;
    logic [31:0] wr_data;
    logic [4:0]  rd_reg1;
    logic [4:0]  rd_reg2;
    logic [31:0] rd_data1;
    logic [31:0] rd_data2;
    logic        ready;

    logic        reset_w;
    logic        wr_en_w;
    logic [5:0]  wr_reg_w;
    logic [63:0] wr_data_w;
    logic [5:0]  rd_reg1_w;
    logic [5:0]  rd_reg2_w;
    logic [63:0] rd_data1_w;
    logic [63:0] rd_data2_w;
    logic        ready_w;

    int n_tests = 0;
    int n_fail  = 0;
    logic [63:0] sb_q[$];

    rv_regfile #(.DATA_W(32), .DEPTH(32)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_reg(wr_reg),
        .wr_data(wr_data), .rd_reg1(rd_reg1), .rd_reg2(rd_reg2),
        .rd_data1(rd_data1), .rd_data2(rd_data2), .ready(ready)
    );

    rv_regfile #(.DATA_W(64), .DEPTH(64)) dut_w (
        .clk(clk), .reset(reset_w), .wr_en(wr_en_w), .wr_reg(wr_reg_w),
        .wr_data(wr_data_w), .rd_reg1(rd_reg1_w), .rd_reg2(rd_reg2_w),
        .rd_data1(rd_data1_w), .rd_data2(rd_data2_w), .ready(ready_w)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [4:0] a1, input logic [4:0] a2,
                      input logic [31:0] e1, input logic [31:0] e2, input string tag);
        sb_q.push_back(64'(e1));
        sb_q.push_back(64'(e2));
        rd_reg1 = a1;
        rd_reg2 = a2;
        #1;
        chk({tag, "/p1"}, 64'(rd_data1), sb_q.pop_front());
        chk({tag, "/p2"}, 64'(rd_data2), sb_q.pop_front());
    endtask

    task automatic rdw(input logic [5:0] a1, input logic [5:0] a2,
                       input logic [63:0] e1, input logic [63:0] e2, input string tag);
        sb_q.push_back(e1);
        sb_q.push_back(e2);
        rd_reg1_w = a1;
        rd_reg2_w = a2;
        #1;
        chk({tag, "/p1"}, rd_data1_w, sb_q.pop_front());
        chk({tag, "/p2"}, rd_data2_w, sb_q.pop_front());
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        wr_en   = 1'b1;
        wr_reg  = a;
        wr_data = d;
        step();
        wr_en   = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        wr_en     = 1'b0;
        wr_reg    = '0;
        wr_data   = '0;
        rd_reg1   = '0;
        rd_reg2   = '0;
        reset_w   = 1'b1;
        wr_en_w   = 1'b0;
        wr_reg_w  = '0;
        wr_data_w = '0;
        rd_reg1_w = '0;
        rd_reg2_w = '0;

        // Reset for one edge
        step();
        chk("reset_ready", 64'(ready), 64'(0));
        rd(5'd1, 5'd31, 32'h0, 32'h0, "reset_rd");

        // Sweep with a write to reg 3 held throughout; it must be ignored
        reset   = 1'b0;
        wr_en   = 1'b1;
        wr_reg  = 5'd3;
        wr_data = 32'hFF;
        for (int i = 1; i <= 32; i++) begin
            step();
            if (i == 32) wr_en = 1'b0;
            chk($sformatf("sweep_ready_%0d", i), 64'(ready), 64'(i == 32));
            rd(5'd3, 5'd3, 32'h0, 32'h0, $sformatf("sweep_rd_%0d", i));
        end

        // Every address reads zero after the sweep
        for (int a = 0; a < 32; a++) begin
            rd(5'(a), 5'(31 - a), 32'h0, 32'h0, $sformatf("zero_%0d", a));
        end

        // Basic write/read and hardwired zero
        wr(5'd5, 32'hDEADBEEF);
        rd(5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, "wr5");
        wr(5'd0, 32'h1234);
        rd(5'd0, 5'd0, 32'h0, 32'h0, "wr0");

        // Same-cycle write/read of reg 7
        wr(5'd7, 32'h11);
        wr_en   = 1'b1;
        wr_reg  = 5'd7;
        wr_data = 32'hA5A5A5A5;
`ifdef RF_BYPASS_EN
        rd(5'd7, 5'd5, 32'hA5A5A5A5, 32'hDEADBEEF, "bypass7");
`else
        rd(5'd7, 5'd5, 32'h11, 32'hDEADBEEF, "bypass7");
`endif
        step();
        // Write to reg 0 in the same cycle as a read of reg 0: never forwarded
        wr_reg  = 5'd0;
        wr_data = 32'hFFFF0000;
        rd(5'd0, 5'd7, 32'h0, 32'hA5A5A5A5, "bypass0");
        step();
        wr_en = 1'b0;

        // Hold with wr_en low
        for (int i = 0; i < 3; i++) step();
        chk("hold_ready", 64'(ready), 64'(1));
        rd(5'd5, 5'd7, 32'hDEADBEEF, 32'hA5A5A5A5, "hold");

        // Fill regs 1..31 with their index
        for (int a = 1; a < 32; a++) wr(5'(a), 32'(a));
        for (int a = 1; a < 32; a++) begin
            rd(5'(a), 5'(32 - a), 32'(a), 32'(32 - a), $sformatf("fill_%0d", a));
        end

        // Reset from READY with a write in flight
        reset   = 1'b1;
        wr_en   = 1'b1;
        wr_reg  = 5'd9;
        wr_data = 32'hBAD;
        step();
        wr_en = 1'b0;
        chk("rst_ready", 64'(ready), 64'(0));
        rd(5'd9, 5'd20, 32'h0, 32'h0, "rst_rd");

        // Sweep to count 10, then reset again for several cycles
        reset = 1'b0;
        for (int i = 0; i < 10; i++) step();
        chk("mid_ready", 64'(ready), 64'(0));
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("hold_rst_ready_%0d", i), 64'(ready), 64'(0));
            rd(5'd15, 5'd31, 32'h0, 32'h0, $sformatf("hold_rst_rd_%0d", i));
        end
        reset = 1'b0;
        for (int i = 1; i <= 32; i++) begin
            step();
            chk($sformatf("resweep_ready_%0d", i), 64'(ready), 64'(i == 32));
        end
        for (int a = 0; a < 32; a++) begin
            rd(5'(a), 5'(a), 32'h0, 32'h0, $sformatf("rezero_%0d", a));
        end

        // Wide instance: 64-bit data, 64 entries
        step();
        chk("w_reset_ready", 64'(ready_w), 64'(0));
        reset_w = 1'b0;
        for (int i = 1; i <= 64; i++) begin
            step();
            chk($sformatf("w_sweep_ready_%0d", i), 64'(ready_w), 64'(i == 64));
        end
        wr_en_w   = 1'b1;
        wr_reg_w  = 6'd63;
        wr_data_w = 64'hFFFF_FFFF_FFFF_FFFF;
        step();
        wr_en_w   = 1'b0;
        rdw(6'd63, 6'd63, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, "w_rd63");
        rdw(6'd0, 6'd62, 64'h0, 64'h0, "w_rd0_62");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
